// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// The IF/ID payload layout and the fetch FSM encoding live here.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // Bubble payload: nop word, zero link address, not valid.
  function automatic ifid_t make_bubble(input logic [XLEN-1:0] nop);
    ifid_t b;
    b.instr    = nop;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

  // Word-align an address (low two bits forced to zero).
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load,
// and an unstalled cycle without a load inserts a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  stall,
  input  logic  load,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= make_bubble(NOP_INSTR);
    end else if (flush) begin
      q <= make_bubble(NOP_INSTR);
    end else if (!stall) begin
      q <= load ? d : make_bubble(NOP_INSTR);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, imem request
// handshake with wrong-path squashing, and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcD,
  input  logic [XLEN-1:0] PCTargetD,
  output logic            ImemReq,
  input  logic            ImemReady,
  input  logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] pend_pc, pend_pc_n;
  logic            imem_req;

  logic            accept_c;
  logic            redirect_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic            load_c;
  ifid_t           ifid_d_c;
  ifid_t           ifid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pend_pc  <= '0;
      imem_req <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pend_pc  <= pend_pc_n;
      imem_req <= (state_n != IDLE);
    end
  end

  // Next-state, next-PC and IF/ID load decision.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_pc_n  = pend_pc;
    load_c     = 1'b0;
    accept_c   = imem_req & ImemReady;
    redirect_c = PCSrcD & ~StallD;
    target_c   = align_word(PCTargetD);
    pc_plus4_c = pc + XLEN'(4);
    ifid_d_c.instr    = InstrF;
    ifid_d_c.pc_plus4 = pc_plus4_c;
    ifid_d_c.valid    = 1'b1;

    unique case (state)
      IDLE: begin
        state_n = REQ;
      end
      REQ: begin
        if (redirect_c) begin
          if (accept_c) begin
            pc_n = target_c;
          end else begin
            pend_pc_n = target_c;
            state_n   = KILL;
          end
        end else if (accept_c && !StallF) begin
          pc_n   = pc_plus4_c;
          load_c = 1'b1;
        end
      end
      KILL: begin
        // The in-flight word is wrong-path; steer to the newest target once it lands.
        if (redirect_c) begin
          pend_pc_n = target_c;
        end
        if (accept_c) begin
          pc_n    = redirect_c ? target_c : pend_pc;
          state_n = REQ;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .rst  (rst),
    .flush(FlushD),
    .stall(StallD),
    .load (load_c),
    .d    (ifid_d_c),
    .q    (ifid_q)
  );

  assign ImemReq  = imem_req;
  assign PCF      = pc;
  assign InstrD   = ifid_q.instr;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural fetch model checked
// every cycle, plus directed vectors with literal expectations.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcD, ImemReady;
  logic [31:0] PCTargetD;
  logic        ImemReq;
  logic [31:0] InstrF, PCF, InstrD, PCPlus4D;
  logic        ValidD;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Behavioural model state.
  logic        m_req;
  logic [31:0] m_pc;
  logic        m_squash;
  logic [31:0] m_dest;
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;

  always #5 clk = ~clk;

  // Instruction memory contents: word index i holds 0x20080001 + i*0x00010001.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2008_0001 + 32'h0001_0001 * (a >> 2);
  endfunction

  assign InstrF = mem(PCF);

  fetch_stage dut (
    .clk      (clk),
    .rst      (rst),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcD   (PCSrcD),
    .PCTargetD(PCTargetD),
    .ImemReq  (ImemReq),
    .ImemReady(ImemReady),
    .InstrF   (InstrF),
    .PCF      (PCF),
    .InstrD   (InstrD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Model: one fetch outstanding at a time; a redirect without a returned
  // word leaves a wrong-path fetch whose data must be thrown away.
  always @(posedge clk or posedge rst) begin
    logic acc, redir, word_ok;
    logic [31:0] tgt;
    if (rst) begin
      m_req = 1'b0; m_pc = 32'h0; m_squash = 1'b0; m_dest = 32'h0;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      acc     = m_req && ImemReady;
      redir   = PCSrcD && !StallD;
      tgt     = {PCTargetD[31:2], 2'b00};
      word_ok = m_req && !m_squash && !redir && acc && !StallF;
      if (FlushD) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!StallD) begin
        if (word_ok) begin
          m_instr = mem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end else begin
          m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end
      end
      if (!m_req) begin
        m_req = 1'b1;
      end else if (m_squash) begin
        if (redir) m_dest = tgt;
        if (acc) begin
          m_pc = m_dest; m_squash = 1'b0;
        end
      end else if (redir) begin
        if (acc) m_pc = tgt;
        else begin
          m_dest = tgt; m_squash = 1'b1;
        end
      end else if (word_ok) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pcf",    PCF,              m_pc);
      chk("m_req",    {31'h0, ImemReq}, {31'h0, m_req});
      chk("m_instrd", InstrD,           m_instr);
      chk("m_pc4d",   PCPlus4D,         m_pc4);
      chk("m_validd", {31'h0, ValidD},  {31'h0, m_valid});
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrcD = 0;
    PCTargetD = 32'h0; ImemReady = 1'b1;
    cyc(); cyc();
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_req", {31'h0, ImemReq}, 32'h0);
    chk("rst_valid", {31'h0, ValidD}, 32'h0);
    rst = 1'b0; chk_en = 1'b1;

    // 1: straight-line fetch.
    cyc();
    chk("t1_req", {31'h0, ImemReq}, 32'h1);
    chk("t1_pcf0", PCF, 32'h0);
    chk("t1_valid0", {31'h0, ValidD}, 32'h0);
    cyc();
    chk("t1_pcf4", PCF, 32'h4);
    chk("t1_instr0", InstrD, 32'h2008_0001);
    chk("t1_pc4_0", PCPlus4D, 32'h4);
    chk("t1_valid1", {31'h0, ValidD}, 32'h1);
    cyc();
    chk("t1_pcf8", PCF, 32'h8);
    chk("t1_instr1", InstrD, 32'h2009_0002);
    chk("t1_pc4_1", PCPlus4D, 32'h8);

    // 2: memory not ready for two cycles at 0x8.
    ImemReady = 1'b0;
    cyc();
    chk("t2_pcf_a", PCF, 32'h8);
    chk("t2_valid_a", {31'h0, ValidD}, 32'h0);
    cyc();
    chk("t2_pcf_b", PCF, 32'h8);
    chk("t2_valid_b", {31'h0, ValidD}, 32'h0);
    ImemReady = 1'b1;
    cyc();
    chk("t2_pcf_c", PCF, 32'hC);
    chk("t2_instr", InstrD, 32'h200A_0003);
    chk("t2_pc4", PCPlus4D, 32'hC);
    cyc();
    chk("t3_pcf10", PCF, 32'h10);

    // 3: redirect with accept, misaligned target.
    PCSrcD = 1'b1; PCTargetD = 32'h103;
    cyc();
    PCSrcD = 1'b0;
    chk("t3_pcf100", PCF, 32'h100);
    chk("t3_valid0", {31'h0, ValidD}, 32'h0);
    cyc();
    chk("t3_instr", InstrD, 32'h2048_0041);
    chk("t3_pc4", PCPlus4D, 32'h104);

    // 4: redirects while the fetch at 0x20 is outstanding.
    PCSrcD = 1'b1; PCTargetD = 32'h20;
    cyc();
    chk("t4_pcf20", PCF, 32'h20);
    ImemReady = 1'b0; PCTargetD = 32'h200;
    cyc();
    chk("t4_hold_a", PCF, 32'h20);
    PCTargetD = 32'h300;
    cyc();
    chk("t4_hold_b", PCF, 32'h20);
    PCSrcD = 1'b0;
    cyc();
    chk("t4_hold_c", PCF, 32'h20);
    ImemReady = 1'b1;
    cyc();
    chk("t4_pcf300", PCF, 32'h300);
    chk("t4_dropped", {31'h0, ValidD}, 32'h0);
    cyc();
    chk("t4_instr", InstrD, 32'h20C8_00C1);
    chk("t4_pc4", PCPlus4D, 32'h304);

    // 5: stall, flush under stall, then PC wrap.
    StallF = 1'b1; StallD = 1'b1;
    cyc();
    cyc();
    chk("t5_pcf_hold", PCF, 32'h304);
    chk("t5_instr_hold", InstrD, 32'h20C8_00C1);
    FlushD = 1'b1;
    cyc();
    chk("t5_flush_valid", {31'h0, ValidD}, 32'h0);
    chk("t5_flush_instr", InstrD, 32'h0);
    chk("t5_flush_pcf", PCF, 32'h304);
    FlushD = 1'b0; StallF = 1'b0; StallD = 1'b0;
    PCSrcD = 1'b1; PCTargetD = 32'hFFFF_FFFF;
    cyc();
    PCSrcD = 1'b0;
    chk("t5_pcf_top", PCF, 32'hFFFF_FFFC);
    cyc();
    chk("t5_pcf_wrap", PCF, 32'h0);
    chk("t5_instr_top", InstrD, 32'h6007_0000);
    chk("t5_pc4_wrap", PCPlus4D, 32'h0);
    chk("t5_valid_top", {31'h0, ValidD}, 32'h1);

    // Mixed pattern phase, checked by the model only.
    for (int i = 0; i < 60; i++) begin
      ImemReady = (i % 3) != 0;
      PCSrcD    = (i % 7) == 3;
      StallD    = (i % 5) == 4;
      StallF    = StallD && ((i % 2) == 0);
      FlushD    = (i % 11) == 6;
      PCTargetD = 32'(i) * 32'h44 + 32'h2;
      cyc();
    end
    StallF = 0; StallD = 0; FlushD = 0; PCSrcD = 0; ImemReady = 1'b1;
    cyc();

    // 6: async reset while a redirect is pending.
    ImemReady = 1'b0; PCSrcD = 1'b1; PCTargetD = 32'h400;
    cyc();
    PCSrcD = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_pcf", PCF, 32'h0);
    chk("t6_req", {31'h0, ImemReq}, 32'h0);
    chk("t6_valid", {31'h0, ValidD}, 32'h0);
    cyc();
    rst = 1'b0; ImemReady = 1'b1;
    cyc();
    chk("t6_req1", {31'h0, ImemReq}, 32'h1);
    chk("t6_pcf0", PCF, 32'h0);
    cyc();
    chk("t6_pcf4", PCF, 32'h4);
    chk("t6_instr", InstrD, 32'h2008_0001);
    cyc();
    chk("t6_pcf8", PCF, 32'h8);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
